// File: rtl/label_stream_if.sv
// ---------------------------------------------------------------------------
// label_stream_if : score-in / label-out handshake bundle.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface label_stream_if #(
    parameter int N                = 8,
    parameter int CLOG2_NUM_LABELS = 4
) ();
    logic                        score_valid;
    logic                        score_ready;
    logic [N-1:0]                score;
    logic                        label_valid;
    logic                        label_ready;
    logic [CLOG2_NUM_LABELS-1:0] label;
    logic [N-1:0]                label_score;

    modport master (
        output score_valid, score, label_ready,
        input  score_ready, label_valid, label, label_score
    );

    modport slave (
        input  score_valid, score, label_ready,
        output score_ready, label_valid, label, label_score
    );
endinterface

`default_nettype wire

// File: rtl/label_stream_ctrl.sv
// ---------------------------------------------------------------------------
// label_stream_ctrl : streaming argmax over NUM_LABELS scores per sample.
// Optional accuracy counters under LABEL_STREAM_STATS_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module label_stream_ctrl #(
    parameter int N                = 8,
    parameter int NUM_LABELS       = 10,
    parameter int CLOG2_NUM_LABELS = 4
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             flush,
    label_stream_if.slave         lbl_if,
    output logic                  busy
`ifdef LABEL_STREAM_STATS_EN
    ,
    input  wire logic [CLOG2_NUM_LABELS-1:0] exp_label,
    input  wire logic                        stats_clr,
    output logic [15:0]                      sample_cnt,
    output logic [15:0]                      correct_cnt
`endif
);

    localparam logic [CLOG2_NUM_LABELS-1:0] LAST_IDX = CLOG2_NUM_LABELS'(NUM_LABELS - 1);
    localparam logic [CLOG2_NUM_LABELS-1:0] IDX_ONE  = CLOG2_NUM_LABELS'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t                      state;
    state_t                      state_next;
    logic [CLOG2_NUM_LABELS-1:0] idx;
    logic [N-1:0]                best_score;
    logic [CLOG2_NUM_LABELS-1:0] best_idx;
    logic [CLOG2_NUM_LABELS-1:0] label_q;
    logic [N-1:0]                label_score_q;

    logic                        ready;
    logic                        accept;
    logic                        handshake;
    logic                        better;
    logic [N-1:0]                cand_score;
    logic [CLOG2_NUM_LABELS-1:0] cand_idx;

    assign ready      = (state != HOLD);
    assign accept     = lbl_if.score_valid && ready && !flush;
    assign handshake  = (state == HOLD) && lbl_if.label_ready && !flush;
    // Index 0 always seeds the running best; later scores must strictly win
    // so ties resolve to the lowest index.
    assign better     = (idx == '0) || (lbl_if.score > best_score);
    assign cand_score = better ? lbl_if.score : best_score;
    assign cand_idx   = better ? idx : best_idx;

    assign lbl_if.score_ready = ready;
    assign lbl_if.label_valid = (state == HOLD);
    assign lbl_if.label       = label_q;
    assign lbl_if.label_score = label_score_q;
    assign busy               = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_next = COLLECT;
                COLLECT: if (accept && (idx == LAST_IDX)) state_next = HOLD;
                HOLD:    if (lbl_if.label_ready) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx           <= '0;
            best_score    <= '0;
            best_idx      <= '0;
            label_q       <= '0;
            label_score_q <= '0;
        end else if (flush) begin
            idx <= '0;
        end else if (accept) begin
            best_score <= cand_score;
            best_idx   <= cand_idx;
            if (idx == LAST_IDX) begin
                idx           <= '0;
                label_q       <= cand_idx;
                label_score_q <= cand_score;
            end else begin
                idx <= idx + IDX_ONE;
            end
        end
    end

`ifdef LABEL_STREAM_STATS_EN
    logic [CLOG2_NUM_LABELS-1:0] exp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q       <= '0;
            sample_cnt  <= '0;
            correct_cnt <= '0;
        end else begin
            if (accept && (idx == '0)) begin
                exp_q <= exp_label;
            end
            if (stats_clr) begin
                sample_cnt  <= '0;
                correct_cnt <= '0;
            end else if (handshake) begin
                if (sample_cnt != 16'hFFFF) sample_cnt <= sample_cnt + 16'd1;
                if ((label_q == exp_q) && (correct_cnt != 16'hFFFF))
                    correct_cnt <= correct_cnt + 16'd1;
            end
        end
    end
`else
    logic unused_handshake;
    assign unused_handshake = handshake;
`endif

endmodule

`default_nettype wire
